// File: rtl/abro_pkg.sv
// Shared state encodings for the ABRO sequence detector.
package abro_pkg;

    typedef enum logic [3:0] {
        S_WAIT  = 4'd0,
        S_GOT_A = 4'd1,
        S_GOT_B = 4'd2,
        S_EMIT  = 4'd3,
        S_DONE  = 4'd4
    } abro_state_e;

endpackage

// File: rtl/abro_state_machine.sv
// ABRO detector: pulse O once after both A and B have been seen since reset.
// Define ABRO_REARM_EN to return from S_DONE to S_WAIT once A and B are both low.
module abro_state_machine
    import abro_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       A,
    input  logic       B,
    output logic       O,
    output logic [3:0] state
);

    abro_state_e state_q;
    abro_state_e state_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_WAIT;
        case (state_q)
            S_WAIT: begin
                if (A && B)  state_d = S_EMIT;
                else if (A)  state_d = S_GOT_A;
                else if (B)  state_d = S_GOT_B;
                else         state_d = S_WAIT;
            end
            S_GOT_A: state_d = B ? S_EMIT : S_GOT_A;
            S_GOT_B: state_d = A ? S_EMIT : S_GOT_B;
            S_EMIT:  state_d = S_DONE;
            S_DONE: begin
`ifdef ABRO_REARM_EN
                state_d = (!A && !B) ? S_WAIT : S_DONE;
`else
                state_d = S_DONE;
`endif
            end
            // Unused codes recover to S_WAIT.
            default: state_d = S_WAIT;
        endcase
    end

    assign O     = (state_q == S_EMIT);
    assign state = state_q;

endmodule

// File: tb/tb_abro_state_machine.sv
// Self-checking bench for abro_state_machine: vector table plus scoreboard queue.
module tb_abro_state_machine;

    logic       clk;
    logic       reset_n;
    logic       A;
    logic       B;
    logic       O;
    logic [3:0] state;

    abro_state_machine dut (
        .clk     (clk),
        .reset_n (reset_n),
        .A       (A),
        .B       (B),
        .O       (O),
        .state   (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rn;
        logic       a;
        logic       b;
        logic [3:0] exp_state;
        logic       exp_o;
    } vec_t;

    typedef struct {
        logic [3:0] exp_state;
        logic       exp_o;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec;
    int   n_bad;

    // Drive inputs away from the active edge, record the expectation, then
    // compare just after the edge that should produce it.
    task automatic apply(input logic rn, input logic a, input logic b,
                         input logic [3:0] es, input logic eo, input int idx);
        exp_t e;
        exp_t got;
        @(negedge clk);
        reset_n = rn;
        A       = a;
        B       = b;
        e.exp_state = es;
        e.exp_o     = eo;
        sb.push_back(e);
        @(posedge clk);
        #1;
        n_vec++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL vec%0d: scoreboard empty", idx);
        end else begin
            got = sb.pop_front();
            if (state !== got.exp_state || O !== got.exp_o) begin
                n_bad++;
                $display("FAIL vec%0d: state=%0d O=%b, required state=%0d O=%b",
                         idx, state, O, got.exp_state, got.exp_o);
            end
        end
    endtask

    initial begin
        n_vec   = 0;
        n_bad   = 0;
        reset_n = 1'b0;
        A       = 1'b0;
        B       = 1'b0;

        // {reset_n, A, B, expected state, expected O}
        vecs.push_back('{1'b0, 1'b1, 1'b1, 4'd0, 1'b0});  // reset hold
        vecs.push_back('{1'b0, 1'b1, 1'b1, 4'd0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 4'd3, 1'b1});  // simultaneous
        vecs.push_back('{1'b1, 1'b1, 1'b1, 4'd4, 1'b0});
        for (int i = 0; i < 8; i++)
            vecs.push_back('{1'b1, 1'b1, 1'b1, 4'd4, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd0, 1'b0});  // A then B
        vecs.push_back('{1'b1, 1'b1, 1'b0, 4'd1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 4'd1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 4'd3, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 4'd4, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd0, 1'b0});  // B then A
        vecs.push_back('{1'b1, 1'b0, 1'b1, 4'd2, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 4'd2, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 4'd3, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 4'd4, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd0, 1'b0});  // reset mid-sequence
        vecs.push_back('{1'b1, 1'b1, 1'b0, 4'd1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 4'd0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 4'd2, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 4'd2, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 4'd3, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 4'd4, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd0, 1'b0});  // A held is one event
        vecs.push_back('{1'b1, 1'b1, 1'b0, 4'd1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 4'd1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 4'd1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 4'd3, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 4'd4, 1'b0});

        foreach (vecs[i])
            apply(vecs[i].rn, vecs[i].a, vecs[i].b,
                  vecs[i].exp_state, vecs[i].exp_o, i);

        // Hand-written tail: behaviour after S_DONE with both inputs low.
`ifdef ABRO_REARM_EN
        apply(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 100);
        apply(1'b1, 1'b1, 1'b1, 4'd3, 1'b1, 101);
        apply(1'b1, 1'b1, 1'b1, 4'd4, 1'b0, 102);
        apply(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 103);
`else
        apply(1'b1, 1'b0, 1'b0, 4'd4, 1'b0, 100);
        apply(1'b1, 1'b1, 1'b1, 4'd4, 1'b0, 101);
        apply(1'b1, 1'b1, 1'b1, 4'd4, 1'b0, 102);
        apply(1'b1, 1'b0, 1'b0, 4'd4, 1'b0, 103);
`endif
        // Reset always restarts, then a fresh sequence fires again.
        apply(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 104);
        apply(1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 105);
        apply(1'b1, 1'b1, 1'b1, 4'd3, 1'b1, 106);
        apply(1'b1, 1'b0, 1'b0, 4'd4 & {4{1'b1}}, 1'b0, 107);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, required completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
        $fatal(1);
    end

endmodule
